// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl -- sequences a stream of complex samples into an array of PEs
// and collects their results back into a single stream.
//
// Loading: PE_NUM*LOAD_NUM accepted samples are dealt out LOAD_NUM at a time,
// PE0 first, each one registered onto pe_load_data with the matching one-hot
// pe_load_v bit. Collecting: every cycle with any pe_out_v bit set forwards
// the lowest-index PE's word to m_data/m_pe_id one cycle later. After
// PE_NUM*OUT_NUM forwarded words the block returns to IDLE.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_data    input sample stream, s_ready is registered
//   pe_load_v/_data   one-hot load strobe and shared load word to the PEs
//   pe_out_v/pe_out   per-PE result valid and result word (PE i at slice i)
//   m_valid/m_data    collected output stream (no backpressure)
//   m_pe_id           source PE of m_data
//   busy              high whenever the FSM is not in IDLE
//   err               sticky flags: [0] output collision, [1] watchdog timeout
//
// Build option: define PE_ARRAY_CTRL_WATCHDOG_EN to compile in a watchdog
// that aborts WAIT/COLLECT after TIMEOUT cycles without a forwarded word.
// Without it err[1] is tied low and WAIT holds indefinitely.
module pe_array_ctrl #(
   parameter int PE_NUM     = 4,
   parameter int LOAD_NUM   = 16,
   parameter int OUT_NUM    = 4,
   parameter int TIMEOUT    = 1024,
   parameter int DATA_WIDTH = 16,
   localparam int DW   = 2 * DATA_WIDTH,
   localparam int ID_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_valid,
   input  logic [DW-1:0]                  s_data,
   output logic                           s_ready,
   output logic [PE_NUM-1:0]              pe_load_v,
   output logic [DW-1:0]                  pe_load_data,
   input  logic [PE_NUM-1:0]              pe_out_v,
   input  logic [PE_NUM-1:0][DW-1:0]      pe_out,
   output logic                           m_valid,
   output logic [DW-1:0]                  m_data,
   output logic [ID_W-1:0]                m_pe_id,
   output logic                           busy,
   output logic [1:0]                     err
);

   localparam int WC_W = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
   localparam int OC_W = (PE_NUM * OUT_NUM > 1) ? $clog2(PE_NUM * OUT_NUM) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, COLLECT} state_e;

   state_e              state_q, state_d;
   logic                s_ready_q, s_ready_d;
   logic [PE_NUM-1:0]   pe_load_v_q, pe_load_v_d;
   logic [DW-1:0]       pe_load_data_q, pe_load_data_d;
   logic                m_valid_q, m_valid_d;
   logic [DW-1:0]       m_data_q, m_data_d;
   logic [ID_W-1:0]     m_pe_id_q, m_pe_id_d;
   logic [1:0]          err_q, err_d;
   logic [WC_W-1:0]     wcnt_q, wcnt_d;
   logic [ID_W-1:0]     psel_q, psel_d;
   logic [OC_W-1:0]     ocnt_q, ocnt_d;

`ifdef PE_ARRAY_CTRL_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0]     wd_q, wd_d;
`endif

   logic                any_v, multi_v;
   logic [ID_W-1:0]     sel_idx;

   // Lowest set index wins; x & (x-1) is nonzero iff two or more bits are set.
   always_comb begin
      sel_idx = '0;
      for (int i = PE_NUM - 1; i >= 0; i--) begin
         if (pe_out_v[i]) sel_idx = ID_W'(i);
      end
      any_v   = |pe_out_v;
      multi_v = |(pe_out_v & (pe_out_v - PE_NUM'(1)));
   end

   always_comb begin
      state_d        = state_q;
      s_ready_d      = 1'b0;
      pe_load_v_d    = '0;
      pe_load_data_d = pe_load_data_q;
      m_valid_d      = 1'b0;
      m_data_d       = m_data_q;
      m_pe_id_d      = m_pe_id_q;
      err_d          = err_q;
      wcnt_d         = wcnt_q;
      psel_d         = psel_q;
      ocnt_d         = ocnt_q;
`ifdef PE_ARRAY_CTRL_WATCHDOG_EN
      wd_d           = '0;
`endif
      unique case (state_q)
         IDLE: begin
            wcnt_d = '0;
            psel_d = '0;
            ocnt_d = '0;
            if (s_valid) begin
               state_d   = LOAD;
               s_ready_d = 1'b1;
               err_d     = 2'b00;
            end
         end
         LOAD: begin
            s_ready_d = 1'b1;
            if (s_valid && s_ready_q) begin
               pe_load_v_d[psel_q] = 1'b1;
               pe_load_data_d      = s_data;
               if (wcnt_q == WC_W'(LOAD_NUM - 1)) begin
                  wcnt_d = '0;
                  if (psel_q == ID_W'(PE_NUM - 1)) begin
                     psel_d    = '0;
                     s_ready_d = 1'b0;
                     state_d   = WAIT;
                  end else begin
                     psel_d = psel_q + ID_W'(1);
                  end
               end else begin
                  wcnt_d = wcnt_q + WC_W'(1);
               end
            end
         end
         WAIT, COLLECT: begin
            if (any_v) begin
               m_valid_d = 1'b1;
               m_data_d  = pe_out[sel_idx];
               m_pe_id_d = sel_idx;
               if (multi_v) err_d[0] = 1'b1;
               state_d = COLLECT;
               if (ocnt_q == OC_W'(PE_NUM * OUT_NUM - 1)) begin
                  ocnt_d  = '0;
                  state_d = IDLE;
               end else begin
                  ocnt_d = ocnt_q + OC_W'(1);
               end
            end
`ifdef PE_ARRAY_CTRL_WATCHDOG_EN
            else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               err_d[1] = 1'b1;
               state_d  = IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
`ifndef PE_ARRAY_CTRL_WATCHDOG_EN
      err_d[1] = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         s_ready_q      <= 1'b0;
         pe_load_v_q    <= '0;
         pe_load_data_q <= '0;
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_pe_id_q      <= '0;
         err_q          <= 2'b00;
         wcnt_q         <= '0;
         psel_q         <= '0;
         ocnt_q         <= '0;
`ifdef PE_ARRAY_CTRL_WATCHDOG_EN
         wd_q           <= '0;
`endif
      end else begin
         state_q        <= state_d;
         s_ready_q      <= s_ready_d;
         pe_load_v_q    <= pe_load_v_d;
         pe_load_data_q <= pe_load_data_d;
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_pe_id_q      <= m_pe_id_d;
         err_q          <= err_d;
         wcnt_q         <= wcnt_d;
         psel_q         <= psel_d;
         ocnt_q         <= ocnt_d;
`ifdef PE_ARRAY_CTRL_WATCHDOG_EN
         wd_q           <= wd_d;
`endif
      end
   end

   assign s_ready      = s_ready_q;
   assign pe_load_v    = pe_load_v_q;
   assign pe_load_data = pe_load_data_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_pe_id      = m_pe_id_q;
   assign busy         = (state_q != IDLE);
   assign err          = err_q;

endmodule
